// File: rtl/seg_scan_driver.sv
// Double-buffered, time-multiplexed 7-segment scan driver with binary digit select.
// Optional leading-zero suppression is built when LEADING_ZERO_BLANK_EN is defined.
module seg_scan_driver #(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 50
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    output logic [2:0]              sel,
    output logic [7:0]              seg,
    output logic [3:0]              mul_out,
    output logic                    frame_done
);

    localparam int              PW         = $clog2(SCAN_DIV);
    localparam logic [PW-1:0]   PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [2:0]      IDX_LAST   = 3'(NUM_DIGITS - 1);

    logic [PW-1:0]           presc_q, presc_d;
    logic [2:0]              idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] act_dig_q, act_dig_d;
    logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
    logic [NUM_DIGITS-1:0]   act_blank_q, act_blank_d;
    logic [4*NUM_DIGITS-1:0] pend_dig_q, pend_dig_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic [NUM_DIGITS-1:0]   pend_blank_q, pend_blank_d;
    logic                    pend_vld_q, pend_vld_d;
    logic [2:0]              sel_q, sel_d;
    logic [7:0]              seg_q, seg_d;
    logic [3:0]              mul_q, mul_d;
    logic                    fdone_q, fdone_d;

    logic                    tick, wrap;
    logic [NUM_DIGITS-1:0]   lz;
    logic [3:0]              cur_dig;
    logic                    cur_dp, cur_hide;

    function automatic logic [6:0] seg7_decode(input logic [3:0] v);
        case (v)
            4'd0:    seg7_decode = 7'h3F;
            4'd1:    seg7_decode = 7'h06;
            4'd2:    seg7_decode = 7'h5B;
            4'd3:    seg7_decode = 7'h4F;
            4'd4:    seg7_decode = 7'h66;
            4'd5:    seg7_decode = 7'h6D;
            4'd6:    seg7_decode = 7'h7D;
            4'd7:    seg7_decode = 7'h07;
            4'd8:    seg7_decode = 7'h7F;
            4'd9:    seg7_decode = 7'h6F;
            default: seg7_decode = 7'h79;
        endcase
    endfunction

    assign tick = (presc_q == PRESC_LAST);
    assign wrap = tick && (idx_q == IDX_LAST);

    // Scan timing and buffer control
    always_comb begin
        presc_d      = presc_q + PW'(1);
        idx_d        = idx_q;
        act_dig_d    = act_dig_q;
        act_dp_d     = act_dp_q;
        act_blank_d  = act_blank_q;
        pend_dig_d   = pend_dig_q;
        pend_dp_d    = pend_dp_q;
        pend_blank_d = pend_blank_q;
        pend_vld_d   = pend_vld_q;

        if (tick) begin
            presc_d = '0;
            idx_d   = wrap ? 3'd0 : idx_q + 3'd1;
        end

        // A load that lands on the wrap edge bypasses the pending buffer
        if (wrap) begin
            if (load) begin
                act_dig_d   = digits_in;
                act_dp_d    = dp_in;
                act_blank_d = blank_in;
                pend_vld_d  = 1'b0;
            end else if (pend_vld_q) begin
                act_dig_d   = pend_dig_q;
                act_dp_d    = pend_dp_q;
                act_blank_d = pend_blank_q;
                pend_vld_d  = 1'b0;
            end
        end else if (load) begin
            pend_dig_d   = digits_in;
            pend_dp_d    = dp_in;
            pend_blank_d = blank_in;
            pend_vld_d   = 1'b1;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic nz_seen;

    always_comb begin
        nz_seen = 1'b0;
        lz      = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (act_dig_d[4*i +: 4] != 4'd0) nz_seen = 1'b1;
            lz[i] = ~nz_seen;
        end
    end
`else
    assign lz = '0;
`endif

    // Outputs are computed from next-state values so select and segments never skew
    always_comb begin
        cur_dig  = 4'd0;
        cur_dp   = 1'b0;
        cur_hide = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_d == 3'(i)) begin
                cur_dig  = act_dig_d[4*i +: 4];
                cur_dp   = act_dp_d[i];
                cur_hide = act_blank_d[i] | lz[i];
            end
        end
        sel_d   = idx_d;
        mul_d   = cur_dig;
        seg_d   = cur_hide ? 8'h00 : {cur_dp, seg7_decode(cur_dig)};
        fdone_d = wrap;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q      <= '0;
            idx_q        <= '0;
            act_dig_q    <= '0;
            act_dp_q     <= '0;
            act_blank_q  <= '0;
            pend_dig_q   <= '0;
            pend_dp_q    <= '0;
            pend_blank_q <= '0;
            pend_vld_q   <= 1'b0;
            sel_q        <= '0;
            seg_q        <= '0;
            mul_q        <= '0;
            fdone_q      <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            act_dig_q    <= act_dig_d;
            act_dp_q     <= act_dp_d;
            act_blank_q  <= act_blank_d;
            pend_dig_q   <= pend_dig_d;
            pend_dp_q    <= pend_dp_d;
            pend_blank_q <= pend_blank_d;
            pend_vld_q   <= pend_vld_d;
            sel_q        <= sel_d;
            seg_q        <= seg_d;
            mul_q        <= mul_d;
            fdone_q      <= fdone_d;
        end
    end

    assign sel        = sel_q;
    assign seg        = seg_q;
    assign mul_out    = mul_q;
    assign frame_done = fdone_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with SCAN_DIV=4, NUM_DIGITS=8 (one frame = 32 cycles).
// Expectations adapt to LEADING_ZERO_BLANK_EN where suppression changes the segments.
module tb_seg_scan_driver;

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [31:0] digits_in;
    logic [7:0]  dp_in;
    logic [7:0]  blank_in;
    logic [2:0]  sel;
    logic [7:0]  seg;
    logic [3:0]  mul_out;
    logic        frame_done;

    int tests = 0;
    int fails = 0;
    int n = 0;

    seg_scan_driver #(.NUM_DIGITS(8), .SCAN_DIV(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .blank_in   (blank_in),
        .sel        (sel),
        .seg        (seg),
        .mul_out    (mul_out),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic step_to(input int t);
        while (n < t) tick();
    endtask

    task automatic do_load(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] bl);
        load      = 1'b1;
        digits_in = d;
        dp_in     = dp;
        blank_in  = bl;
        tick();
        load      = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; digits_in = '0; dp_in = '0; blank_in = '0;
        tick(); tick();
        chk("rst_sel", 32'(sel), 0);
        chk("rst_seg", 32'(seg), 'h00);
        chk("rst_mul", 32'(mul_out), 0);
        chk("rst_fd", 32'(frame_done), 0);
        rst = 1'b0;
        n = 0;

        // 1: free-running scan with empty buffers
        tick();
        chk("t1_seg_first", 32'(seg), 'h3F);
        chk("t1_sel_first", 32'(sel), 0);
        step_to(4);  chk("t1_sel_n4", 32'(sel), 1);
        step_to(13); chk("t1_sel_n13", 32'(sel), 3);
        chk("t1_seg_n13", 32'(seg), LZ ? 'h00 : 'h3F);
        step_to(31); chk("t1_sel_n31", 32'(sel), 7);
        chk("t1_fd_n31", 32'(frame_done), 0);
        step_to(32); chk("t1_sel_wrap", 32'(sel), 0);
        chk("t1_fd_wrap", 32'(frame_done), 1);
        step_to(33); chk("t1_fd_after", 32'(frame_done), 0);

        // 2: mid-frame load waits for the next wrap
        step_to(40); do_load(32'h76543210, 8'h00, 8'h00);
        step_to(44); chk("t2_sel_cur", 32'(sel), 3);
        chk("t2_seg_cur", 32'(seg), LZ ? 'h00 : 'h3F);
        step_to(64); chk("t2_seg_d0", 32'(seg), 'h3F);
        chk("t2_fd", 32'(frame_done), 1);
        step_to(76); chk("t2_sel3", 32'(sel), 3);
        chk("t2_seg3", 32'(seg), 'h4F);
        chk("t2_mul3", 32'(mul_out), 3);
        step_to(92); chk("t2_seg7", 32'(seg), 'h07);

        // 3: two loads in one frame, last wins, dp on digit 2
        step_to(100); do_load(32'h11111111, 8'h00, 8'h00);
        step_to(104); chk("t3_seg_old", 32'(seg), 'h5B);
        step_to(110); do_load(32'h99999999, 8'h04, 8'h00);
        step_to(128); chk("t3_seg0", 32'(seg), 'h6F);
        chk("t3_mul0", 32'(mul_out), 9);
        step_to(136); chk("t3_seg2_dp", 32'(seg), 'hEF);
        step_to(156); chk("t3_seg7", 32'(seg), 'h6F);

        // 4: load on the wrap edge overrides a queued pending frame
        step_to(150); do_load(32'h99999999, 8'h00, 8'h00);
        step_to(159); do_load(32'h00000005, 8'h00, 8'h00);
        chk("t4_sel", 32'(sel), 0);
        chk("t4_seg", 32'(seg), 'h6D);
        chk("t4_mul", 32'(mul_out), 5);
        chk("t4_fd", 32'(frame_done), 1);
        step_to(164); chk("t4_seg1", 32'(seg), LZ ? 'h00 : 'h3F);
        step_to(192); chk("t4_seg_next", 32'(seg), 'h6D);

        // 5: invalid BCD code and blanking
        step_to(200); do_load(32'h000C0070, 8'h00, 8'h02);
        step_to(224); chk("t5_seg0", 32'(seg), 'h3F);
        step_to(228); chk("t5_seg1_blank", 32'(seg), 'h00);
        chk("t5_mul1_raw", 32'(mul_out), 7);
        step_to(240); chk("t5_sel4", 32'(sel), 4);
        chk("t5_seg4", 32'(seg), 'h79);
        chk("t5_mul4", 32'(mul_out), 'hC);

        // 6: reset mid-frame discards pending data
        step_to(260); do_load(32'h88888888, 8'hFF, 8'h00);
        step_to(276); chk("t6_sel_pre", 32'(sel), 5);
        rst = 1'b1;
        tick();
        chk("t6_rst_sel", 32'(sel), 0);
        chk("t6_rst_seg", 32'(seg), 'h00);
        chk("t6_rst_fd", 32'(frame_done), 0);
        chk("t6_rst_mul", 32'(mul_out), 0);
        rst = 1'b0;
        n = 0;
        tick();
        chk("t6_seg_rel", 32'(seg), 'h3F);
        step_to(32); chk("t6_fd_wrap", 32'(frame_done), 1);
        chk("t6_seg_wrap", 32'(seg), 'h3F);
        chk("t6_mul_wrap", 32'(mul_out), 0);

        // Leading-zero pattern 00000120
        step_to(40); do_load(32'h00000120, 8'h00, 8'h00);
        step_to(64); chk("lz_seg0", 32'(seg), 'h3F);
        step_to(68); chk("lz_seg1", 32'(seg), 'h5B);
        chk("lz_mul1", 32'(mul_out), 2);
        step_to(72); chk("lz_seg2", 32'(seg), 'h06);
        step_to(76); chk("lz_seg3", 32'(seg), LZ ? 'h00 : 'h3F);
        step_to(92); chk("lz_seg7", 32'(seg), LZ ? 'h00 : 'h3F);
        chk("lz_mul7", 32'(mul_out), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
Downstream display stage for the digit counters. Takes a packed vector of BCD digits, double-buffers it so that frames never tear, and time-multiplexes the digits onto a single 7-segment bus. Drives a binary digit select with a programmable per-digit dwell time, and reports frame completion to upstream logic.

Parameters:
NUM_DIGITS, 8, number of scanned digits, 1..8; sel is always 3 bits.
SCAN_DIV, 50, clk cycles each digit is held, >=2.

Ports:
clk  in  1  system clock; all logic is on its rising edge.
rst  in  1  synchronous, active-high reset.
load  in  1  one-cycle strobe that captures digits_in, dp_in and blank_in.
digits_in  in  4*NUM_DIGITS  BCD digits; digit i is in bits [4i+3:4i]; digit 0 is the rightmost.
dp_in  in  NUM_DIGITS  decimal point enable per digit.
blank_in  in  NUM_DIGITS  forces a digit fully dark when 1.
sel  out  3  binary index of the active digit.
seg  out  8  active-high segments; bit7 = dp, bits6..0 = g..a.
mul_out  out  4  raw BCD value of the active digit.
frame_done  out  1  one-cycle pulse at each frame wrap.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: sel=0, seg=8'h00, mul_out=0, frame_done=0, prescaler=0, scan index=0, active and pending buffers all zero, pending_valid=0.
- Prescaler: counts 0..SCAN_DIV-1.
  - At SCAN_DIV-1 it returns to 0 and the scan index advances.
  - The index runs 0..NUM_DIGITS-1 and wraps to 0.
  - Each digit is therefore held exactly SCAN_DIV cycles.
- Output registers: sel, mul_out and seg are registered and updated on the same edge. They are mutually consistent every cycle, with no skew between select and segments.
  - sel = index.
  - mul_out = active digit[index].
  - seg = decode(active digit[index]) with bit7 = active dp[index].
- Decode table, hex, bit7 excluded: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F. Codes 10..15 display 'E' = 79.
- Blanking: a blanked digit gives seg = 00, dp included. mul_out still shows the raw value.
- First cycle after rst deasserts: seg = 3F, because the active digit 0 holds zero.
- Double buffer, normal load: load=1 captures the inputs into the pending buffer and sets pending_valid. A later load before transfer overwrites pending (last wins).
- Double buffer, transfer:
  - Occurs on the wrap edge, when the index goes from NUM_DIGITS-1 to 0.
  - If pending_valid=1, then active<=pending and pending_valid<=0.
  - Digit 0 shown on that same edge already uses the new data.
- Double buffer, load on the wrap edge: the inputs go directly to active, and pending_valid is cleared. They are visible from digit 0 of that frame.
- frame_done: high for exactly the one cycle following each wrap edge.
- NUM_DIGITS=1: every SCAN_DIV period is a wrap. frame_done pulses every SCAN_DIV cycles and sel stays 0.
- Reset mid-frame: every register returns to its reset value on the next edge. Pending data is discarded.

Optional Feature:
Macro LEADING_ZERO_BLANK_EN.
- Defined: zero digits from the most significant digit downward are blanked (seg=00, dp included) until the first non-zero digit. Digit 0 is never suppressed. Evaluated on the active buffer, combined by OR with blank_in.
- Undefined: zeros are shown as 3F unless blank_in is set.

Test Plan:
1. Reset and scan (SCAN_DIV=4, NUM_DIGITS=8, no load) -> sel steps 0..7 every 4 cycles, seg=3F throughout, frame_done pulses every 32 cycles.
2. Load digits 7..0 = 7,6,5,4,3,2,1,0 mid-frame -> the current frame is unchanged. From the next wrap: sel=3 gives seg=4F and mul_out=3; sel=7 gives seg=07.
3. Two loads in one frame (all 1s, then all 9s), plus dp_in[2]=1 -> the next frame shows all 6F, and digit 2 shows EF. No frame ever shows 06.
4. Load pulse exactly on the wrap edge with digit0=5 -> seg=6D at sel=0 in that frame. pending_valid is 0 afterwards.
5. digit4=4'hC and blank_in[1]=1 -> sel=4 gives seg=79 and mul_out=C. sel=1 gives seg=00 with mul_out holding the raw value.
6. rst asserted at sel=5 with pending loaded -> next cycle sel=0, seg=00, frame_done=0. After release, seg=3F and the pending data is never displayed. With LEADING_ZERO_BLANK_EN and digits 00000120 -> digits 7..3 show 00; digits 2,1,0 show 06,5B,3F.
